// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the fetch-control slice:
//   - FSM state encodings (legacy 2-bit values kept stable for trace tools)
//   - redirect-target alignment mask and helper
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

   localparam logic [1:0] FC_BOOT = 2'd0;
   localparam logic [1:0] FC_RUN  = 2'd1;
   localparam logic [1:0] FC_TRAP = 2'd2;

   // Instructions are word aligned; any set bit under this mask is a bad target.
   localparam logic [1:0] MISALIGN_MASK = 2'b11;

   function automatic logic is_misaligned(input logic [1:0] addr_lsb);
      return (addr_lsb & MISALIGN_MASK) != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
// Bundles the decode/execute request side and the fetch-unit command side of
// the fetch controller.
//   master : the controller (consumes stall/redirect/trap_clear, drives fetch_*)
//   slave  : the surrounding pipeline / fetch unit
// Signals:
//   stall, redirect, redirect_addr[XLEN], trap_clear          (to controller)
//   fetch_en, fetch_jmp, fetch_jmp_addr[XLEN], squash,
//   boot_done, exc_misaligned, exc_addr[XLEN], fetch_count[32] (from controller)
// -----------------------------------------------------------------------------
interface fetch_ctrl_if #(
   parameter int XLEN = 32
);
   logic            stall;
   logic            redirect;
   logic [XLEN-1:0] redirect_addr;
   logic            trap_clear;

   logic            fetch_en;
   logic            fetch_jmp;
   logic [XLEN-1:0] fetch_jmp_addr;
   logic            squash;
   logic            boot_done;
   logic            exc_misaligned;
   logic [XLEN-1:0] exc_addr;
   logic [31:0]     fetch_count;

   modport master (
      input  stall, redirect, redirect_addr, trap_clear,
      output fetch_en, fetch_jmp, fetch_jmp_addr, squash,
             boot_done, exc_misaligned, exc_addr, fetch_count
   );

   modport slave (
      output stall, redirect, redirect_addr, trap_clear,
      input  fetch_en, fetch_jmp, fetch_jmp_addr, squash,
             boot_done, exc_misaligned, exc_addr, fetch_count
   );
endinterface

// File: rtl/fetch_ctrl_squash_timer.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_squash_timer
// Down-counter that keeps the squash window open for a programmable number of
// cycles after each (re)load. A load while busy restarts the window.
// Ports:
//   clk       in  clock
//   rst_n     in  asynchronous active-low reset
//   load      in  restart the window this edge
//   load_val  in  window length in cycles
//   busy      out registered, high while the window is open
// -----------------------------------------------------------------------------
module fetch_ctrl_squash_timer #(
   parameter int SQUASH_CYCLES = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 load,
   input  logic [$clog2(SQUASH_CYCLES+1)-1:0]   load_val,
   output logic                                 busy
);

   localparam int CW = $clog2(SQUASH_CYCLES + 1);

   logic [CW-1:0] cnt_p1;
   logic          busy_p1;

   // busy is computed one edge ahead so the output comes straight off a flop
   // and still equals (cnt_p1 != 0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p1  <= '0;
         busy_p1 <= 1'b0;
      end else if (load) begin
         cnt_p1  <= load_val;
         busy_p1 <= (load_val != '0);
      end else if (cnt_p1 != '0) begin
         cnt_p1  <= cnt_p1 - CW'(1);
         busy_p1 <= (cnt_p1 > CW'(1));
      end else begin
         busy_p1 <= 1'b0;
      end
   end

   assign busy = busy_p1;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Sequences the instruction-fetch/PC stage: holds fetch off for BOOT_CYCLES
// after reset, gates per-cycle fetch enable on decode stall, forwards execute
// redirects to the fetch unit, squashes wrong-path instructions and traps
// misaligned redirect targets. All outputs are registered.
// Ports:
//   clk    in  clock, all state on posedge
//   rst_n  in  asynchronous active-low reset
//   bus    fetch_ctrl_if.master:
//            stall, redirect, redirect_addr, trap_clear          (inputs)
//            fetch_en, fetch_jmp, fetch_jmp_addr, squash,
//            boot_done, exc_misaligned, exc_addr, fetch_count    (outputs)
// -----------------------------------------------------------------------------
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int              XLEN          = 32,
   parameter int              BOOT_CYCLES   = 4,
   parameter int              SQUASH_CYCLES = 2,
   parameter logic [XLEN-1:0] TRAP_VEC      = XLEN'('h10)
) (
   input  logic        clk,
   input  logic        rst_n,
   fetch_ctrl_if.master bus
);

   localparam int BW  = $clog2(BOOT_CYCLES + 1);
   localparam int SQW = $clog2(SQUASH_CYCLES + 1);

   logic [1:0]      state_p1;
   logic [BW-1:0]   boot_cnt_p1;
   logic            fetch_en_p1;
   logic            fetch_jmp_p1;
   logic [XLEN-1:0] fetch_jmp_addr_p1;
   logic            boot_done_p1;
   logic            exc_p1;
   logic [XLEN-1:0] exc_addr_p1;
   logic [31:0]     fetch_count_p1;

   logic            sq_load;
   logic            sq_busy;

   // Any redirect accepted in RUN (aligned or trapping) and every trap exit
   // open a fresh squash window.
   always_comb begin
      sq_load = 1'b0;
      if (state_p1 == FC_RUN && bus.redirect)
         sq_load = 1'b1;
      if (state_p1 == FC_TRAP && bus.trap_clear)
         sq_load = 1'b1;
   end

   fetch_ctrl_squash_timer #(
      .SQUASH_CYCLES (SQUASH_CYCLES)
   ) u_squash_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (sq_load),
      .load_val (SQW'(SQUASH_CYCLES)),
      .busy     (sq_busy)
   );

   // ---- input sample -> registered fetch command ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p1          <= FC_BOOT;
         boot_cnt_p1       <= '0;
         fetch_en_p1       <= 1'b0;
         fetch_jmp_p1      <= 1'b0;
         fetch_jmp_addr_p1 <= '0;
         boot_done_p1      <= 1'b0;
         exc_p1            <= 1'b0;
         exc_addr_p1       <= '0;
         fetch_count_p1    <= '0;
      end else begin
         // Counts cycles in which the fetch unit was enabled; wraps silently.
         if (fetch_en_p1)
            fetch_count_p1 <= fetch_count_p1 + 32'd1;

         case (state_p1)
            FC_BOOT: begin
               fetch_jmp_p1 <= 1'b0;
               if (boot_cnt_p1 == BW'(BOOT_CYCLES - 1)) begin
                  state_p1     <= FC_RUN;
                  boot_done_p1 <= 1'b1;
                  fetch_en_p1  <= 1'b1;
               end else begin
                  boot_cnt_p1  <= boot_cnt_p1 + BW'(1);
                  fetch_en_p1  <= 1'b0;
               end
            end

            FC_RUN: begin
               if (bus.redirect && is_misaligned(bus.redirect_addr[1:0])) begin
                  state_p1     <= FC_TRAP;
                  exc_p1       <= 1'b1;
                  exc_addr_p1  <= bus.redirect_addr;
                  fetch_en_p1  <= 1'b0;
                  fetch_jmp_p1 <= 1'b0;
               end else if (bus.redirect) begin
                  // Redirect beats stall: the instruction held in decode is
                  // wrong-path and gets squashed regardless.
                  fetch_en_p1       <= 1'b1;
                  fetch_jmp_p1      <= 1'b1;
                  fetch_jmp_addr_p1 <= bus.redirect_addr;
               end else begin
                  fetch_en_p1  <= !bus.stall;
                  fetch_jmp_p1 <= 1'b0;
               end
            end

            FC_TRAP: begin
               if (bus.trap_clear) begin
                  state_p1          <= FC_RUN;
                  exc_p1            <= 1'b0;
                  fetch_en_p1       <= 1'b1;
                  fetch_jmp_p1      <= 1'b1;
                  fetch_jmp_addr_p1 <= TRAP_VEC;
               end else begin
                  fetch_en_p1  <= 1'b0;
                  fetch_jmp_p1 <= 1'b0;
               end
            end

            default: begin
               // Unused encoding: fall back to a clean boot sequence.
               state_p1     <= FC_BOOT;
               boot_cnt_p1  <= '0;
               fetch_en_p1  <= 1'b0;
               fetch_jmp_p1 <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fetch_en       = fetch_en_p1;
   assign bus.fetch_jmp      = fetch_jmp_p1;
   assign bus.fetch_jmp_addr = fetch_jmp_addr_p1;
   assign bus.squash         = sq_busy;
   assign bus.boot_done      = boot_done_p1;
   assign bus.exc_misaligned = exc_p1;
   assign bus.exc_addr       = exc_addr_p1;
   assign bus.fetch_count    = fetch_count_p1;

endmodule
